// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if : start/stream/memory-write bundle for program_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic                start;
  logic [ADDR_W:0]     len;
  logic                in_valid;
  logic [2*DATA_W-1:0] in_data;
  logic                in_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_function;
  logic [DATA_W-1:0]   mem_value;
  logic                cpu_hold;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_function, mem_value,
    input  cpu_hold, busy, done, err
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_function, mem_value,
    output cpu_hold, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader : streams a {function,value} image into instruction memory,
// verifies an XOR checksum and releases the CPU hold only on a good load.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module program_loader #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 0
) (
  input wire               clk,
  input wire               rst_n,
  program_loader_if.slave  bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   c_tlast = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [ADDR_W:0]     r_n;
  logic [ADDR_W:0]     r_count;
  logic [2*DATA_W-1:0] r_csum;
  logic [TW-1:0]       r_tcnt;
  logic                r_err;
  logic                r_hold;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_fn;
  logic [DATA_W-1:0]   r_val;

  logic [ADDR_W:0]     w_n;
  logic                w_start;
  logic                w_beat;
  logic                w_last;
  logic                w_active;
  logic                w_timeout;

  always_comb begin
    w_n       = (bus.len > c_depth) ? c_depth : bus.len;
    w_start   = (r_state == S_IDLE) && bus.start;
    w_beat    = bus.in_valid && r_ready;
    w_last    = (r_count == r_n - 1'b1);
    w_active  = (r_state == S_LOAD) || (r_state == S_CHECK);
    // Counter only runs while waiting; a beat on the deadline cycle wins.
    w_timeout = (TIMEOUT > 0) && w_active && !w_beat && (r_tcnt == c_tlast);
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = (w_n == '0) ? S_CHECK : S_LOAD;
      S_LOAD: begin
        if (w_beat && w_last) w_state_nx = S_CHECK;
        else if (w_timeout)   w_state_nx = S_DONE;
      end
      S_CHECK: if (w_beat || w_timeout) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Handshake/status flags are derived from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nx == S_LOAD) || (w_state_nx == S_CHECK);
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n     <= '0;
      r_count <= '0;
      r_csum  <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
      r_hold  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_fn    <= '0;
      r_val   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_n     <= w_n;
        r_count <= '0;
        r_csum  <= '0;
        r_tcnt  <= '0;
        r_err   <= 1'b0;
        r_hold  <= 1'b1;
      end
      if (w_active && TIMEOUT > 0) begin
        if (w_beat) r_tcnt <= '0;
        else        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_timeout) r_err <= 1'b1;
      if (r_state == S_LOAD && w_beat) begin
        r_we    <= 1'b1;
        r_addr  <= r_count[ADDR_W-1:0];
        r_fn    <= bus.in_data[2*DATA_W-1:DATA_W];
        r_val   <= bus.in_data[DATA_W-1:0];
        r_csum  <= r_csum ^ bus.in_data;
        r_count <= r_count + 1'b1;
      end
      if (r_state == S_CHECK && w_beat && (bus.in_data != r_csum)) r_err <= 1'b1;
      if (r_state == S_DONE) r_hold <= r_err;
    end
  end

  assign bus.in_ready     = r_ready;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_function = r_fn;
  assign bus.mem_value    = r_val;
  assign bus.cpu_hold     = r_hold;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;

endmodule

`default_nettype wire
